// File: rtl/csa_pkg.sv
// csa_pkg: shared state type, default widths and slice-count helper for csa_accumulator
package csa_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} csa_state_e;
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction
endpackage

// File: rtl/csa_accumulator_3to2.sv
// csa_3to2: N-bit 3:2 compressor, ports a/b/c in, s (xor) and maj (unshifted carry) out
module csa_3to2 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] maj
);
  assign s = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save operand accumulator with slice-serial resolve; ports clk/rst_n, in_valid/in_ready/in_data, flush, clear, out_valid/out_ready/out_sum/out_ovf, plus out_count when CSA_ACC_CNT_EN is defined
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE,
  parameter int CNTW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CSA_ACC_CNT_EN
  output logic [CNTW-1:0]  out_count,
`endif
  output logic             out_ovf
);
  localparam int NS = nslice(WIDTH, SLICE);
  localparam int KW = NS > 1 ? $clog2(NS) : 1;
  csa_state_e state_q, state_d;
  logic [WIDTH-1:0] s_q, c_q, res_q, res_d, csa_s, csa_maj;
  logic ovf_q, cin_q, last, drop;
  logic [KW-1:0] k_q;
  logic [SLICE:0] slice_sum;
  csa_3to2 #(.N(WIDTH)) u_csa (.a(s_q), .b(c_q), .c(in_data), .s(csa_s), .maj(csa_maj));
  assign in_ready = state_q == ACCUM;
  assign last = k_q == KW'(NS - 1);
  assign drop = state_q != ACCUM && (clear || (state_q == HOLD && out_ready));
  assign slice_sum = {1'b0, s_q[k_q*SLICE +: SLICE]} + {1'b0, c_q[k_q*SLICE +: SLICE]} + {{SLICE{1'b0}}, cin_q};
  always_comb begin
    res_d = res_q;
    res_d[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   state_d = flush && !clear ? RESOLVE : ACCUM;
      RESOLVE: state_d = clear ? ACCUM : (last ? HOLD : RESOLVE);
      HOLD:    state_d = clear || out_ready ? ACCUM : HOLD;
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ACCUM;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      k_q <= '0;
      cin_q <= 1'b0;
      res_q <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (state_q == ACCUM) begin
      k_q <= '0;
      cin_q <= 1'b0;
      if (clear) begin
        s_q <= in_valid ? in_data : '0;
        c_q <= '0;
        ovf_q <= 1'b0;
      end else if (in_valid) begin
        s_q <= csa_s;
        c_q <= csa_maj << 1;
        ovf_q <= ovf_q | csa_maj[WIDTH-1];
      end
    end else if (drop) begin
      s_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      out_valid <= 1'b0;
    end else if (state_q == RESOLVE) begin
      res_q <= res_d;
      cin_q <= slice_sum[SLICE];
      k_q <= k_q + 1'b1;
      if (last) begin
        out_sum <= res_d;
        out_ovf <= ovf_q | slice_sum[SLICE];
        out_valid <= 1'b1;
      end
    end
`ifdef CSA_ACC_CNT_EN
  logic [CNTW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      out_count <= '0;
    end else if (state_q == ACCUM) cnt_q <= clear ? CNTW'(in_valid) : (in_valid && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q);
    else if (drop) cnt_q <= '0;
    else if (state_q == RESOLVE && last) out_count <= cnt_q;
`endif
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed and randomized checks of csa_accumulator against a plain-arithmetic sum model
module tb_csa_accumulator;
  localparam int W = 32, SL = 8, NS = W / SL, CW = 8;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, flush = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum;
`ifdef CSA_ACC_CNT_EN
  logic [CW-1:0] out_count;
`endif
  int tests = 0, fails = 0;
  logic [63:0] m_total = '0;
  int m_cd = 0, m_n = 0, m_cnt = 0;
  bit m_hold = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;
  always #5 clk = ~clk;
  csa_accumulator #(.WIDTH(W), .SLICE(SL), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef CSA_ACC_CNT_EN
    .out_count(out_count),
`endif
    .out_ovf(out_ovf)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step();
    if (!rst_n) begin
      m_total = '0; m_cd = 0; m_hold = 0; m_valid = 0; m_sum = '0; m_ovf = 0; m_n = 0; m_cnt = 0;
    end else if (!m_hold && m_cd == 0) begin
      if (clear) begin
        m_total = in_valid ? 64'(in_data) : 64'd0;
        m_n = in_valid ? 1 : 0;
      end else begin
        if (in_valid) begin
          m_total += 64'(in_data);
          m_n++;
        end
        if (flush) m_cd = NS;
      end
    end else if (clear || (m_hold && out_ready)) begin
      m_total = '0; m_cd = 0; m_hold = 0; m_valid = 0; m_n = 0;
    end else if (!m_hold) begin
      m_cd--;
      if (m_cd == 0) begin
        m_hold = 1;
        m_valid = 1;
        m_sum = m_total[W-1:0];
        m_ovf = (m_total >> W) != 0;
        m_cnt = m_n > (2**CW - 1) ? 2**CW - 1 : m_n;
      end
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("in_ready", in_ready, !m_hold && m_cd == 0);
    chk("out_valid", out_valid, m_valid);
    chk("out_sum", out_sum, m_sum);
    chk("out_ovf", out_ovf, m_ovf);
`ifdef CSA_ACC_CNT_EN
    if (m_valid) chk("out_count", out_count, m_cnt);
`endif
  end
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit f, input bit c, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; flush = f; clear = c; out_ready = r;
  endtask
  task automatic push(input logic [W-1:0] d);
    cyc(1, d, 0, 0, 0);
  endtask
  task automatic do_flush(input bit v, input logic [W-1:0] d, input logic [W-1:0] es, input bit eo, input string nm);
    int n;
    cyc(v, d, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, NS);
    chk({nm, " sum"}, out_sum, es);
    chk({nm, " ovf"}, out_ovf, eo);
  endtask
  task automatic handshake();
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0);
    chk("handshake drop", out_valid, 0);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_sum", out_sum, 0);
    chk("rst out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    push(32'h1); push(32'hFF); push(32'hFF00);
    do_flush(0, '0, 32'h0001_0000, 0, "sum3");
    handshake();
    push(32'hFFFF_FFFF); push(32'h1);
    do_flush(0, '0, 32'h0, 1, "wrap");
    handshake();
    push(32'h5);
    do_flush(0, '0, 32'h5, 0, "sticky clr");
    for (int i = 0; i < 6; i++) begin
      cyc(1, $urandom, 0, 0, 0);
      chk("bp sum", out_sum, 32'h5);
      chk("bp in_ready", in_ready, 0);
    end
    handshake();
    push(32'h3);
    do_flush(0, '0, 32'h3, 0, "after bp");
    handshake();
    push(32'h20);
    do_flush(1, 32'h10, 32'h30, 0, "flush+op");
    handshake();
    do_flush(0, '0, 32'h0, 0, "empty");
    handshake();
    push(32'h9);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort rst valid", out_valid, 0);
    chk("abort rst ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h7);
    do_flush(0, '0, 32'h7, 0, "after rst");
    handshake();
    push(32'h4);
    do_flush(0, '0, 32'h4, 0, "pre clear");
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0);
    chk("clear hold valid", out_valid, 0);
    chk("clear hold ready", in_ready, 1);
    push(32'h7);
    do_flush(0, '0, 32'h7, 0, "after clear");
    handshake();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
    cyc(0, '0, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
